vanilla_barrier_node: RTL and testbench

- Per-tile barrier tree node.
- Opposite end of the tile's barrier CSR interface: consumes the tile's Pi bit (barrier_data_o) and produces its Po bit (barrier_data_i).
- Combines Pi with neighbour gather bits selected by the barcfg source mask, forwards one gather bit toward the barcfg destination direction, and broadcasts the release back down to the tile and to every source neighbour.
- Sits in the tile beside the core, wired to the per-direction barrier links.

---
 rtl/vanilla_barrier_node.sv | 145 ++++++++++++++
 tb/tb_vanilla_barrier_node.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vanilla_barrier_node.sv
// Per-tile barrier tree node: gathers Pi plus masked neighbour bits, forwards up, broadcasts release.
// Optional performance counters are enabled with `define VANILLA_BARRIER_PERF_EN.
module vanilla_barrier_node #(
    parameter int barrier_dirs_p = 5
`ifdef VANILLA_BARRIER_PERF_EN
    , parameter int perf_width_p = 32
`endif
    , localparam int barrier_lg_dirs_lp = (barrier_dirs_p + 1 > 1) ? $clog2(barrier_dirs_p + 1) : 1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [barrier_dirs_p-1:0]     barrier_src_r_i,
    input  logic [barrier_lg_dirs_lp-1:0] barrier_dest_r_i,
    input  logic                          pi_i,
    output logic                          po_o,
    input  logic [barrier_dirs_p-1:0]     up_i,
    output logic [barrier_dirs_p-1:0]     up_o,
    input  logic [barrier_dirs_p-1:0]     down_i,
    output logic [barrier_dirs_p-1:0]     down_o,
    output logic                          busy_o
`ifdef VANILLA_BARRIER_PERF_EN
    , output logic [perf_width_p-1:0]     barrier_count_o
    , output logic [perf_width_p-1:0]     wait_cycles_o
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, REL = 2'd2} state_e;

    state_e                    state_r, state_n;
    logic                      sense_r, sense_n;
    logic                      po_r, po_n;
    logic                      busy_r;
    logic [barrier_dirs_p-1:0] up_r, up_n;
    logic [barrier_dirs_p-1:0] down_r, down_n;
    logic [barrier_dirs_p-1:0] src_r, src_n;
    logic [barrier_dirs_p-1:0] dest_r, dest_n;

    logic [barrier_dirs_p-1:0] src_val;
    logic [barrier_dirs_p-1:0] inv_sense;
    logic [barrier_dirs_p-1:0] dest_live;
    logic [barrier_dirs_p-1:0] rel_mask;
    logic                      gather_done;
    logic                      release_match;
    logic                      unused_up0;

    assign unused_up0 = up_i[0];
    assign src_val    = {up_i[barrier_dirs_p-1:1], pi_i};
    assign inv_sense  = {barrier_dirs_p{~sense_r}};
    assign rel_mask   = {src_r[barrier_dirs_p-1:1], 1'b0};

    // Destination held one-hot over neighbour links; an all-zero vector means root
    // (dest 0, dest == barrier_dirs_p, or any out-of-range value).
    always_comb begin
        dest_live = '0;
        for (int d = 1; d < barrier_dirs_p; d++) begin
            dest_live[d] = (barrier_dest_r_i == barrier_lg_dirs_lp'(d));
        end
    end

    assign gather_done   = (barrier_src_r_i != '0) &&
                           ((barrier_src_r_i & (src_val ^ inv_sense)) == '0);
    assign release_match = (((down_i ^ inv_sense) & dest_r) == '0);

    // NOTE: every *_n gets its default first, so no path through the case infers a latch.
    always_comb begin
        state_n = state_r;
        sense_n = sense_r;
        po_n    = po_r;
        up_n    = up_r;
        down_n  = down_r;
        src_n   = src_r;
        dest_n  = dest_r;
        case (state_r)
            IDLE: begin
                if (gather_done) begin
                    src_n  = barrier_src_r_i;
                    dest_n = dest_live;
                    if (dest_live == '0) begin
                        state_n = REL;
                    end else begin
                        up_n    = (up_r & ~dest_live) | (dest_live & inv_sense);
                        state_n = UP;
                    end
                end
            end
            UP: begin
                if (release_match) state_n = REL;
            end
            REL: begin
                sense_n = ~sense_r;
                po_n    = ~sense_r;
                down_n  = (down_r & ~rel_mask) | (rel_mask & inv_sense);
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= IDLE;
            sense_r <= 1'b0;
            po_r    <= 1'b0;
            busy_r  <= 1'b0;
            up_r    <= '0;
            down_r  <= '0;
            src_r   <= '0;
            dest_r  <= '0;
        end else begin
            state_r <= state_n;
            sense_r <= sense_n;
            po_r    <= po_n;
            busy_r  <= (state_n != IDLE);
            up_r    <= up_n;
            down_r  <= down_n;
            src_r   <= src_n;
            dest_r  <= dest_n;
        end
    end

    assign po_o   = po_r;
    assign up_o   = up_r;
    assign down_o = down_r;
    assign busy_o = busy_r;

`ifdef VANILLA_BARRIER_PERF_EN
    logic [perf_width_p-1:0] barrier_count_r;
    logic [perf_width_p-1:0] wait_cycles_r;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            barrier_count_r <= '0;
            wait_cycles_r   <= '0;
        end else begin
            if (state_r == REL) barrier_count_r <= barrier_count_r + perf_width_p'(1);
            if (state_r == UP)  wait_cycles_r   <= wait_cycles_r + perf_width_p'(1);
        end
    end

    assign barrier_count_o = barrier_count_r;
    assign wait_cycles_o   = wait_cycles_r;
`endif

endmodule

// File: tb/tb_vanilla_barrier_node.sv
// Self-checking bench for vanilla_barrier_node: table-driven root/non-root vectors plus
// hand-written reset, config-change and (with VANILLA_BARRIER_PERF_EN) counter sequences.
module tb_vanilla_barrier_node;

    logic       clk_i;
    logic       reset_i;
    logic [4:0] barrier_src_r_i;
    logic [2:0] barrier_dest_r_i;
    logic       pi_i;
    logic       po_o;
    logic [4:0] up_i;
    logic [4:0] up_o;
    logic [4:0] down_i;
    logic [4:0] down_o;
    logic       busy_o;
`ifdef VANILLA_BARRIER_PERF_EN
    logic [3:0] barrier_count_o;
    logic [3:0] wait_cycles_o;
`endif

    int checks = 0;
    int errors = 0;

    vanilla_barrier_node #(
        .barrier_dirs_p(5)
`ifdef VANILLA_BARRIER_PERF_EN
        , .perf_width_p(4)
`endif
    ) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .barrier_src_r_i (barrier_src_r_i),
        .barrier_dest_r_i(barrier_dest_r_i),
        .pi_i            (pi_i),
        .po_o            (po_o),
        .up_i            (up_i),
        .up_o            (up_o),
        .down_i          (down_i),
        .down_o          (down_o),
        .busy_o          (busy_o)
`ifdef VANILLA_BARRIER_PERF_EN
        , .barrier_count_o(barrier_count_o)
        , .wait_cycles_o  (wait_cycles_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        string      name;
        logic [4:0] src;
        logic [2:0] dest;
        logic       pi;
        logic [4:0] up;
        logic [4:0] down;
        int         cyc;
        logic       exp_po;
        logic [4:0] exp_up;
        logic [4:0] exp_down;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic po, input logic [4:0] up,
                              input logic [4:0] down, input logic busy);
        check({name, "_po"},   {31'd0, po_o},   {31'd0, po});
        check({name, "_up"},   {27'd0, up_o},   {27'd0, up});
        check({name, "_down"}, {27'd0, down_o}, {27'd0, down});
        check({name, "_busy"}, {31'd0, busy_o}, {31'd0, busy});
    endtask

    // Advance n rising edges, then settle 1ns so outputs are sampled away from the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [4:0] src, input logic [2:0] dest, input logic pi,
                         input logic [4:0] up, input logic [4:0] down);
        barrier_src_r_i  = src;
        barrier_dest_r_i = dest;
        pi_i             = pi;
        up_i             = up;
        down_i           = down;
    endtask

`ifdef VANILLA_BARRIER_PERF_EN
    logic sense_m;
    int   wait_m;
    int   count_m;

    task automatic do_barrier(input int k);
        pi_i = ~sense_m;
        step(1);
        repeat (k) step(1);
        down_i[1] = ~sense_m;
        step(2);
        check("perf_po", {31'd0, po_o}, {31'd0, ~sense_m});
        sense_m = ~sense_m;
        wait_m  += k + 1;
        count_m += 1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //               name            src       dest  pi    up        down      cyc  po    up_o      down_o    busy
        vecs.push_back('{"idle_root",    5'b00001, 3'd5, 1'b0, 5'b00000, 5'b00000, 1,   1'b0, 5'b00000, 5'b00000, 1'b0});
        vecs.push_back('{"root_p1_e1",   5'b00001, 3'd5, 1'b1, 5'b00000, 5'b00000, 1,   1'b0, 5'b00000, 5'b00000, 1'b1});
        vecs.push_back('{"root_p1_e2",   5'b00001, 3'd5, 1'b1, 5'b00000, 5'b00000, 1,   1'b1, 5'b00000, 5'b00000, 1'b0});
        vecs.push_back('{"root_p0_e1",   5'b00001, 3'd5, 1'b0, 5'b00000, 5'b00000, 1,   1'b1, 5'b00000, 5'b00000, 1'b1});
        vecs.push_back('{"root_p0_e2",   5'b00001, 3'd5, 1'b0, 5'b00000, 5'b00000, 1,   1'b0, 5'b00000, 5'b00000, 1'b0});
        vecs.push_back('{"root3_hold",   5'b00111, 3'd5, 1'b1, 5'b00010, 5'b00000, 50,  1'b0, 5'b00000, 5'b00000, 1'b0});
        vecs.push_back('{"root3_e1",     5'b00111, 3'd5, 1'b1, 5'b00110, 5'b00000, 1,   1'b0, 5'b00000, 5'b00000, 1'b1});
        vecs.push_back('{"root3_e2",     5'b00111, 3'd5, 1'b1, 5'b00110, 5'b00000, 1,   1'b1, 5'b00000, 5'b00110, 1'b0});
        vecs.push_back('{"root3_back",   5'b00111, 3'd5, 1'b0, 5'b00000, 5'b00000, 2,   1'b0, 5'b00000, 5'b00000, 1'b0});
        vecs.push_back('{"nr_up",        5'b00001, 3'd2, 1'b1, 5'b00000, 5'b00000, 1,   1'b0, 5'b00100, 5'b00000, 1'b1});
        vecs.push_back('{"nr_wait",      5'b00001, 3'd2, 1'b1, 5'b00000, 5'b00000, 8,   1'b0, 5'b00100, 5'b00000, 1'b1});
        vecs.push_back('{"nr_glitch",    5'b00001, 3'd2, 1'b1, 5'b00000, 5'b01000, 1,   1'b0, 5'b00100, 5'b00000, 1'b1});
        vecs.push_back('{"nr_glitch_off",5'b00001, 3'd2, 1'b1, 5'b00000, 5'b00000, 1,   1'b0, 5'b00100, 5'b00000, 1'b1});
        vecs.push_back('{"nr_rel_e1",    5'b00001, 3'd2, 1'b1, 5'b00000, 5'b00100, 1,   1'b0, 5'b00100, 5'b00000, 1'b1});
        vecs.push_back('{"nr_rel_e2",    5'b00001, 3'd2, 1'b1, 5'b00000, 5'b00100, 1,   1'b1, 5'b00100, 5'b00000, 1'b0});

        reset_i = 1'b1;
        drive(5'b00000, 3'd0, 1'b0, 5'b00000, 5'b00000);
        #2;
        check_outs("reset", 1'b0, 5'b00000, 5'b00000, 1'b0);
        step(2);
        reset_i = 1'b0;
        step(1);

        foreach (vecs[i]) begin
            drive(vecs[i].src, vecs[i].dest, vecs[i].pi, vecs[i].up, vecs[i].down);
            step(vecs[i].cyc);
            check_outs(vecs[i].name, vecs[i].exp_po, vecs[i].exp_up, vecs[i].exp_down, vecs[i].exp_busy);
        end

        // Mid-UP asynchronous reset (sense is 1, po_o is 1 here).
        drive(5'b00011, 3'd2, 1'b0, 5'b00000, 5'b00100);
        step(1);
        check_outs("pre_rst_up", 1'b1, 5'b00000, 5'b00000, 1'b1);
        reset_i = 1'b1;
        #1;
        check_outs("async_rst", 1'b0, 5'b00000, 5'b00000, 1'b0);
        step(2);
        reset_i = 1'b0;
        step(3);
        check_outs("post_rst_quiet", 1'b0, 5'b00000, 5'b00000, 1'b0);

        // Fresh barrier from sense 0, then barcfg changes while in UP.
        drive(5'b00011, 3'd2, 1'b1, 5'b00010, 5'b00000);
        step(1);
        check_outs("fresh_up", 1'b0, 5'b00100, 5'b00000, 1'b1);
        drive(5'b01001, 3'd3, 1'b1, 5'b00000, 5'b01000);
        step(3);
        check_outs("cfg_chg_hold", 1'b0, 5'b00100, 5'b00000, 1'b1);
        down_i = 5'b00100;
        step(1);
        check_outs("cfg_rel_e1", 1'b0, 5'b00100, 5'b00000, 1'b1);
        step(1);
        check_outs("cfg_rel_e2", 1'b1, 5'b00100, 5'b00010, 1'b0);

        // Next barrier picks up the new config: dest 3, src bits {3,0}.
        drive(5'b01001, 3'd3, 1'b0, 5'b00000, 5'b00100);
        step(1);
        check_outs("newcfg_up", 1'b1, 5'b00100, 5'b00010, 1'b1);
        step(1);
        check_outs("newcfg_rel", 1'b1, 5'b00100, 5'b00010, 1'b1);
        step(1);
        check_outs("newcfg_done", 1'b0, 5'b00100, 5'b00010, 1'b0);

`ifdef VANILLA_BARRIER_PERF_EN
        reset_i = 1'b1;
        step(1);
        reset_i = 1'b0;
        drive(5'b00001, 3'd1, 1'b0, 5'b00000, 5'b00000);
        step(1);
        check("perf_rst_count", {28'd0, barrier_count_o}, 32'd0);
        check("perf_rst_wait",  {28'd0, wait_cycles_o},   32'd0);
        sense_m = 1'b0;
        wait_m  = 0;
        count_m = 0;
        do_barrier(4);
        do_barrier(0);
        do_barrier(7);
        check("perf_count3", {28'd0, barrier_count_o}, 32'd3);
        check("perf_wait3",  {28'd0, wait_cycles_o},   32'(wait_m % 16));
        for (int i = 0; i < 14; i++) do_barrier(0);
        check("perf_count_wrap", {28'd0, barrier_count_o}, 32'd1);
        check("perf_wait_wrap",  {28'd0, wait_cycles_o},   32'(wait_m % 16));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
